// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter. Each wide beat is emitted as one narrow beat per
// kept lane, in ascending lane order. Lanes whose keep bit is clear are skipped.
module stream_downsize #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_DATA_RATIO = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  typedef logic [T_DATA_RATIO-1:0] lane_mask_t;
  typedef logic [T_DATA_WIDTH-1:0] lane_t;

  lane_t      buf_data [T_DATA_RATIO];
  lane_mask_t rem_keep;
  logic       buf_last;

  lane_mask_t lane_sel;   // one-hot: lowest lane still to be sent
  lane_mask_t rem_after;  // rem_keep with that lane removed
  logic       final_lane;
  logic       s_hs;
  logic       m_hs;
  lane_t      data_sel;

  assign lane_sel   = rem_keep & (~rem_keep + lane_mask_t'(1));
  assign rem_after  = rem_keep & (rem_keep - lane_mask_t'(1));
  assign final_lane = (rem_keep != '0) && (rem_after == '0);

  assign m_valid_o = (rem_keep != '0);
  assign m_last_o  = buf_last && final_lane;
  assign m_hs      = m_valid_o && m_ready_i;

  // Accept a new beat when empty, or when the last pending lane leaves this cycle.
  assign s_ready_o = rst_n && (!m_valid_o || (m_hs && final_lane));
  assign s_hs      = s_valid_i && s_ready_o;

  // AND-OR mux over the one-hot lane select; yields zero when nothing is pending.
  always_comb begin
    // NOTE: default first so every path assigns data_sel and no latch is inferred.
    data_sel = '0;
    for (int i = 0; i < T_DATA_RATIO; i++) begin
      if (lane_sel[i]) data_sel = data_sel | buf_data[i];
    end
  end

  assign m_data_o = data_sel;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_keep <= '0;
      buf_last <= 1'b0;
      // NOTE: the data array is reset too so that m_data_o is defined as zero after reset.
      for (int i = 0; i < T_DATA_RATIO; i++) buf_data[i] <= '0;
    end else if (s_hs) begin
      // Either empty or the final lane is leaving now, so overwriting loses nothing.
      buf_data <= s_data_i;
      rem_keep <= s_keep_i;
      buf_last <= s_last_i;
    end else if (m_hs) begin
      rem_keep <= rem_after;
    end
  end

endmodule
